// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-requester memory arbiter: FSM state and
// read-return owner tag.
package mem_arbiter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_STARVED = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive cycles in which the debug requester asks but is not
// served. limit_hit_o flags the cycle whose closing edge brings the count
// to the limit, so the arbiter can switch to STARVED on that same edge.
module mem_arb_starve_ctr
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             dbg_req_i,
  input  logic             dbg_gnt_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             limit_hit_o
);

  localparam logic [CNT_W-1:0] LIMIT_C = STARVE_LIMIT[CNT_W-1:0];

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear when DBG is idle or served, otherwise saturating +1.
  always_comb begin
    cnt_d = cnt_q;
    if (!dbg_req_i || dbg_gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q < LIMIT_C) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    limit_hit_o = (cnt_d == LIMIT_C);
  end

  // Count register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU, DBG) arbiter in front of a single-port memory with
// one-cycle read latency. CPU has priority unless DBG has been starved for
// STARVE_LIMIT cycles, in which case DBG gets exactly one forced slot.
//
// Handshake: a requester holds req (and its addr/wdata/we) stable until it
// sees gnt high in the same cycle; gnt high means the access is taken at the
// next rising edge. Read data returns as rvalid/rdata one cycle after gnt,
// only on the owner's port; the arbiter stores no request data.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output arb_state_e        arb_state_o,
  output logic [CNT_W-1:0]  starve_cnt_o
);

  arb_state_e state_q, state_d;
  owner_e     tag_q, tag_d;
  logic       limit_hit;

  mem_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clock       (clock),
    .resetn      (resetn),
    .dbg_req_i   (dbg_req),
    .dbg_gnt_i   (dbg_gnt),
    .cnt_o       (starve_cnt_o),
    .limit_hit_o (limit_hit)
  );

  // Grant selection and next state; grants are suppressed while in reset.
  always_comb begin
    state_d = state_q;
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        if (cpu_req)      cpu_gnt = 1'b1;
        else if (dbg_req) dbg_gnt = 1'b1;
        if (limit_hit) state_d = ST_STARVED;
      end
      ST_STARVED: begin
        if (dbg_req)      dbg_gnt = 1'b1;
        else if (cpu_req) cpu_gnt = 1'b1;
        // The forced slot is used (or DBG went away): back to CPU priority.
        state_d = ST_NORMAL;
      end
      default: state_d = ST_NORMAL;
    endcase
    if (!resetn) begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
    end
  end

  // Memory port mux and read-owner tag for the access taken this cycle.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    tag_d     = OWN_NONE;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
      mem_re    = ~cpu_we;
      if (!cpu_we) tag_d = OWN_CPU;
    end else if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_we    = dbg_we;
      mem_re    = ~dbg_we;
      if (!dbg_we) tag_d = OWN_DBG;
    end
  end

  // State and owner-tag registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_NORMAL;
      tag_q   <= OWN_NONE;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
    end
  end

  // Read return is steered to the owner; the other port sees zeros.
  always_comb begin
    cpu_rvalid = (tag_q == OWN_CPU);
    dbg_rvalid = (tag_q == OWN_DBG);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
  end

  assign arb_state_o = state_q;

endmodule
